serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full-subtractor cell, purely combinational.
module full_subtractor (
  output logic d,
  output logic br_out,
  input  logic a,
  input  logic b,
  input  logic br_in
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell processes A - B - bin LSB first,
// one bit per clock, and publishes D/bout when the last bit is done.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_shifted;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_br;
  logic             last_bit;

  full_subtractor u_cell (
    .d      (cell_d),
    .br_out (cell_br),
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .br_in  (br)
  );

  assign last_bit    = (cnt == CW'(WIDTH - 1));
  assign res_shifted = {cell_d, res_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            br     <= bin;
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= cell_br;
          res_sr <= res_shifted;
          cnt    <= cnt + CW'(1);
          // The final bit completes the result; publish it in the same edge.
          if (last_bit) begin
            D    <= res_shifted;
            bout <= cell_br;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=16.
module tb_serial_subtractor;

  typedef struct {
    logic [16:0] val;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, bin4, busy4, done4, bout4;
  logic [3:0]  a4, b4, d4;
  logic        start16, bin16, busy16, done16, bout16;
  logic [15:0] a16, b16, d16;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp4[$];
  exp_t exp16[$];
  exp_t e4, e16;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .bin(bin4),
    .busy(busy4), .done(done4), .D(d4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .bin(bin16),
    .busy(busy16), .done(done16), .D(d16), .bout(bout16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [16:0] model4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b} - {4'd0, bi};
    return {12'd0, r};
  endfunction

  function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {16'd0, bi};
  endfunction

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (busy4 && done4) check_eq("busy_and_done4", 1, 0);
    if (busy16 && done16) check_eq("busy_and_done16", 1, 0);
    if (done4) begin
      if (exp4.size() == 0) check_eq("spurious_done4", 1, 0);
      else begin
        e4 = exp4.pop_front();
        check_eq("res4", {59'd0, bout4, d4}, {47'd0, e4.val});
        check_eq("due4", 64'(cyc), 64'(e4.due));
      end
    end
    if (done16) begin
      if (exp16.size() == 0) check_eq("spurious_done16", 1, 0);
      else begin
        e16 = exp16.pop_front();
        check_eq("res16", {47'd0, bout16, d16}, {47'd0, e16.val});
        check_eq("due16", 64'(cyc), 64'(e16.due));
      end
    end
  end

  task automatic wait_done4();
    int n = 0;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done4) check_eq("timeout4", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done16();
    int n = 0;
    while (!done16 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done16) check_eq("timeout16", 0, 1);
    @(negedge clk);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    exp4.push_back('{val: model4(a, b, bi), due: cyc + 1 + 4});
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'(($urandom));
    b4 = 4'(($urandom));
    wait_done4();
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    @(negedge clk);
    a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
    exp16.push_back('{val: model16(a, b, bi), due: cyc + 1 + 16});
    @(negedge clk);
    start16 = 1'b0;
    wait_done16();
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;

    // Reset dominates a pending start
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy4}, 0);
    check_eq("rst_done", {63'd0, done4}, 0);
    check_eq("rst_d", {60'd0, d4}, 0);
    check_eq("rst_bout", {63'd0, bout4}, 0);
    check_eq("rst_d16", {48'd0, d16}, 0);

    // First edge with rst low accepts the held start: 9-3-0
    rst = 1'b0;
    exp4.push_back('{val: model4(4'd9, 4'd3, 1'b0), due: cyc + 1 + 4});
    @(negedge clk);
    start4 = 1'b0;
    check_eq("busy_after_accept", {63'd0, busy4}, 1);
    wait_done4();
    check_eq("d_hold", {60'd0, d4}, 64'd6);

    op4(4'd3, 4'd9, 1'b0);
    op4(4'd0, 4'd0, 1'b1);
    op4(4'd15, 4'd15, 1'b1);

    // Start held high: one op per 6 cycles, operand noise while busy is ignored
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    acc = cyc + 1;
    for (int k = 0; k < 3; k++)
      exp4.push_back('{val: model4(4'd5, 4'd2, 1'b0), due: acc + 6 * k + 4});
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (busy4) begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        bin4 = 1'($urandom);
      end else begin
        a4 = 4'd5; b4 = 4'd2; bin4 = 1'b0;
      end
    end
    start4 = 1'b0;
    wait_done4();
    check_eq("held_drained", 64'(exp4.size()), 0);

    // Reset at edge 2 of an operation aborts it
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", {63'd0, busy4}, 0);
    check_eq("abort_done", {63'd0, done4}, 0);
    check_eq("abort_d", {60'd0, d4}, 0);
    check_eq("abort_bout", {63'd0, bout4}, 0);
    repeat (8) @(negedge clk);
    check_eq("abort_no_done", 64'(exp4.size()), 0);
    op4(4'd9, 4'd3, 1'b0);

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          op4(4'(a), 4'(b), 1'(bi));

    // Random 16-bit vectors plus corners
    op16(16'h0000, 16'hFFFF, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 1000; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));

    repeat (4) @(negedge clk);
    check_eq("q4_drained", 64'(exp4.size()), 0);
    check_eq("q16_drained", 64'(exp16.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
